// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out transmitter with a valid/ready load
// handshake, a per-bit shift enable, an optional even-parity bit, and a Frame
// output that marks the active bit window. All outputs are registered.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1,
  parameter int PARITY_EN = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Load_Data,
  input  logic             Load_Valid,
  output logic             Load_Ready,
  input  logic             Shift_En,
  output logic             Serial_Out,
  output logic             Frame,
  output logic             Busy,
  output logic             Done
);

  localparam int N     = WIDTH + ((PARITY_EN != 0) ? 1 : 0);
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [N-2:0]     shreg_q;   // bits still waiting to go out, next one at [0]
  logic [N-2:0]     shreg_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             ser_q;
  logic             frame_q;
  logic             busy_q;
  logic             done_q;
  logic             ready_q;
  logic [N-1:0]     load_frame;

  // Arrange the word in transmission order (element 0 goes first) and append
  // the even-parity bit last when enabled.
  function automatic logic [N-1:0] build_frame(input logic [WIDTH-1:0] d);
    logic [N-1:0] f;
    f = '0;
    for (int i = 0; i < WIDTH; i++) begin
      f[i] = (LSB_FIRST != 0) ? d[i] : d[WIDTH-1-i];
    end
    if (PARITY_EN != 0) begin
      f[N-1] = ^d;
    end
    return f;
  endfunction

  // Next-state datapath values: load image, shifted remainder, incremented count.
  always_comb begin
    load_frame = build_frame(Load_Data);
    shreg_d    = shreg_q >> 1;
    cnt_d      = cnt_q + 1'b1;
  end

  // Control FSM with registered outputs; reset overrides every other input.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      ser_q   <= 1'b1;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (Load_Valid) begin
            state_q <= SHIFT;
            ser_q   <= load_frame[0];
            shreg_q <= load_frame[N-1:1];
            cnt_q   <= '0;
            frame_q <= 1'b1;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (Shift_En) begin
            if (cnt_q == LAST_CNT) begin
              state_q <= DONE;
              ser_q   <= 1'b1;
              frame_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              ser_q   <= shreg_q[0];
              shreg_q <= shreg_d;
              cnt_q   <= cnt_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ser_q   <= 1'b1;
          frame_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign Serial_Out = ser_q;
  assign Frame      = frame_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Load_Ready = ready_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: one instance LSB-first without
// parity, one MSB-first with parity; table-driven frames plus hand-written
// sequences for bit holding, back-to-back loads and reset abort.
module tb_piso_serializer;

  logic       Clk;
  logic       Reset;
  logic       Shift_En;
  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid;
  logic       a_ready, b_ready;
  logic       a_so, b_so;
  logic       a_frame, b_frame;
  logic       a_busy, b_busy;
  logic       a_done, b_done;

  int total = 0;
  int bad   = 0;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1), .PARITY_EN(0)) dut_a (
    .Clk(Clk), .Reset(Reset), .Load_Data(a_data), .Load_Valid(a_valid),
    .Load_Ready(a_ready), .Shift_En(Shift_En), .Serial_Out(a_so),
    .Frame(a_frame), .Busy(a_busy), .Done(a_done)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(0), .PARITY_EN(1)) dut_b (
    .Clk(Clk), .Reset(Reset), .Load_Data(b_data), .Load_Valid(b_valid),
    .Load_Ready(b_ready), .Shift_En(Shift_En), .Serial_Out(b_so),
    .Frame(b_frame), .Busy(b_busy), .Done(b_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       use_b;
    logic [7:0] data;
    int         nbits;
    logic [8:0] seq;    // seq[i] = i-th bit on the line
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, ".so"},    32'(a_so),    32'd1);
    chk({nm, ".frame"}, 32'(a_frame), 32'd0);
    chk({nm, ".busy"},  32'(a_busy),  32'd0);
    chk({nm, ".done"},  32'(a_done),  32'd0);
    chk({nm, ".ready"}, 32'(a_ready), 32'd1);
  endtask

  // Full frame with Shift_En held high, checked cycle by cycle.
  task automatic send_frame(input int idx, input logic use_b, input logic [7:0] d,
                            input int n, input logic [8:0] seq);
    string nm;
    if (use_b) begin b_data = d; b_valid = 1'b1; end
    else       begin a_data = d; a_valid = 1'b1; end
    Shift_En = 1'b1;
    step();
    a_valid = 1'b0;
    b_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      nm = $sformatf("vec%0d.bit%0d", idx, i);
      chk({nm, ".so"},    32'(use_b ? b_so : a_so),       32'(seq[i]));
      chk({nm, ".frame"}, 32'(use_b ? b_frame : a_frame), 32'd1);
      chk({nm, ".busy"},  32'(use_b ? b_busy : a_busy),   32'd1);
      chk({nm, ".done"},  32'(use_b ? b_done : a_done),   32'd0);
      chk({nm, ".ready"}, 32'(use_b ? b_ready : a_ready), 32'd0);
      step();
    end
    nm = $sformatf("vec%0d.donecyc", idx);
    chk({nm, ".done"},  32'(use_b ? b_done : a_done),   32'd1);
    chk({nm, ".frame"}, 32'(use_b ? b_frame : a_frame), 32'd0);
    chk({nm, ".so"},    32'(use_b ? b_so : a_so),       32'd1);
    chk({nm, ".busy"},  32'(use_b ? b_busy : a_busy),   32'd1);
    chk({nm, ".ready"}, 32'(use_b ? b_ready : a_ready), 32'd0);
    step();
    nm = $sformatf("vec%0d.after", idx);
    chk({nm, ".ready"}, 32'(use_b ? b_ready : a_ready), 32'd1);
    chk({nm, ".done"},  32'(use_b ? b_done : a_done),   32'd0);
    chk({nm, ".busy"},  32'(use_b ? b_busy : a_busy),   32'd0);
  endtask

  initial begin
    logic [7:0] s3c;
    logic [7:0] s11;
    logic [7:0] s22;

    // Hand-computed line sequences, element 0 first.
    vecs[0] = '{1'b0, 8'hA5, 8, 9'b0_1010_0101}; // LSB first: 1,0,1,0,0,1,0,1
    vecs[1] = '{1'b0, 8'h3C, 8, 9'b0_0011_1100}; // 0,0,1,1,1,1,0,0
    vecs[2] = '{1'b0, 8'h80, 8, 9'b0_1000_0000}; // 0,0,0,0,0,0,0,1
    vecs[3] = '{1'b1, 8'hA5, 9, 9'b0_1010_0101}; // MSB first 1,0,1,0,0,1,0,1 + parity 0
    vecs[4] = '{1'b1, 8'h07, 9, 9'b1_1110_0000}; // 0,0,0,0,0,1,1,1 + parity 1
    vecs[5] = '{1'b1, 8'h01, 9, 9'b1_1000_0000}; // 0,0,0,0,0,0,0,1 + parity 1

    Reset = 1'b1; Shift_En = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; a_data = 8'h00; b_data = 8'h00;
    step();
    chk_idle("reset");
    chk("reset.b_so", 32'(b_so), 32'd1);
    chk("reset.b_ready", 32'(b_ready), 32'd1);
    Reset = 1'b0;

    // Idle with Shift_En wiggling: nothing should move.
    for (int k = 0; k < 5; k++) begin
      Shift_En = k[0];
      step();
      chk_idle($sformatf("idle%0d", k));
    end

    // Reset and Load_Valid on the same edge: word not captured.
    Reset = 1'b1; a_valid = 1'b1; a_data = 8'h55;
    step();
    Reset = 1'b0; a_valid = 1'b0;
    chk_idle("rst_vs_load");
    step();
    chk_idle("rst_vs_load.next");

    // Table-driven frames.
    for (int v = 0; v < 6; v++) begin
      send_frame(v, vecs[v].use_b, vecs[v].data, vecs[v].nbits, vecs[v].seq);
    end

    // 0x3C with Shift_En pulsed every 4th cycle: each bit held 4 cycles.
    s3c = 8'h3C;
    a_data = s3c; a_valid = 1'b1; Shift_En = 1'b0;
    step();
    a_valid = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      chk($sformatf("slow.c%0d.so", k), 32'(a_so), 32'(s3c[(k-1)/4]));
      chk($sformatf("slow.c%0d.frame", k), 32'(a_frame), 32'd1);
      Shift_En = ((k % 4) == 0);
      step();
    end
    Shift_En = 1'b0;
    chk("slow.done", 32'(a_done), 32'd1);
    chk("slow.frame_end", 32'(a_frame), 32'd0);
    step();
    chk("slow.ready", 32'(a_ready), 32'd1);

    // Load_Valid held across two words; Load_Data changed mid-frame.
    s11 = 8'h11; s22 = 8'h22;
    a_data = s11; a_valid = 1'b1; Shift_En = 1'b1;
    step();
    a_data = s22;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("b2b.w0.bit%0d", k-1), 32'(a_so), 32'(s11[k-1]));
      chk($sformatf("b2b.w0.frame%0d", k-1), 32'(a_frame), 32'd1);
      step();
    end
    chk("b2b.done", 32'(a_done), 32'd1);
    chk("b2b.gap_done.frame", 32'(a_frame), 32'd0);
    step();
    // First IDLE cycle after DONE: ready with Load_Valid still high -> handshake.
    chk("b2b.idle.ready", 32'(a_ready), 32'd1);
    chk("b2b.idle.frame", 32'(a_frame), 32'd0);
    chk("b2b.idle.done", 32'(a_done), 32'd0);
    step();
    a_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("b2b.w1.bit%0d", k-1), 32'(a_so), 32'(s22[k-1]));
      chk($sformatf("b2b.w1.frame%0d", k-1), 32'(a_frame), 32'd1);
      step();
    end
    chk("b2b.w1.done", 32'(a_done), 32'd1);
    step();
    chk("b2b.w1.ready", 32'(a_ready), 32'd1);

    // Reset after bit 3 of 0xFF aborts the frame without a Done pulse.
    a_data = 8'hFF; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("abort.bit%0d", k), 32'(a_so), 32'd1);
      chk($sformatf("abort.frame%0d", k), 32'(a_frame), 32'd1);
      if (k < 3) step();
    end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk_idle("abort.rst");
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("abort.nodone%0d", k), 32'(a_done), 32'd0);
      chk($sformatf("abort.noframe%0d", k), 32'(a_frame), 32'd0);
    end
    send_frame(9, 1'b0, 8'h01, 8, 9'b0_0000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
